// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT definitions: default sizes, read-side FSM states, bit-reversal helper.
package fft_bitrev_reorder_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LOG2N     = 6;
  localparam int unsigned N         = 2**LOG2N;
  localparam int unsigned MAX_LOG2N = 12;

  typedef enum logic {
    RD_IDLE,
    RD_RUN
  } rd_state_e;

  // Reverses the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx,
                                                  input int unsigned          nbits);
    logic [MAX_LOG2N-1:0] r;
    logic [3:0]           j;
    r = '0;
    for (int unsigned i = 0; i < MAX_LOG2N; i++) begin
      if (i < nbits) begin
        j    = 4'(nbits - 1 - i);
        r[j] = idx[4'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// Simple dual-port RAM for the ping-pong banks: one write port, one registered read port.
//   clk               clock
//   wr_en/addr/data   write port
//   rd_en/addr        read request, rd_data valid the cycle after
module fft_bitrev_reorder_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders one FFT frame from bit-reversed to natural order through two ping-pong banks.
//   clk, rst                    clock, async active-high reset
//   flush                       synchronous abort of all buffered data
//   in_valid/ready/data/last    bit-reversed sample stream (in_last only checked)
//   out_valid/ready/data/last   natural-order stream, out_last with bin N-1
//   err_len                     pulse: in_last disagreed with the internal count
//   frames_done                 frames fully emitted (wrapping)
module fft_bitrev_reorder #(
  parameter int unsigned DATA_W = fft_bitrev_reorder_pkg::DATA_W,
  parameter int unsigned LOG2N  = fft_bitrev_reorder_pkg::LOG2N,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err_len,
  output logic [CNT_W-1:0]  frames_done
);

  import fft_bitrev_reorder_pkg::*;

  rd_state_e            state, state_n;
  logic                 wr_bank, rd_bank;
  logic [LOG2N-1:0]     wr_cnt, rd_cnt;
  logic [1:0]           full, full_n;
  logic                 in_fire, out_fire, wr_end;
  logic                 rd_go, rd_issue, rd_end;
  logic [MAX_LOG2N-1:0] wr_cnt_ext;
  logic [LOG2N-1:0]     wr_idx;
  logic [DATA_W-1:0]    rd_data;

  always_comb begin
    wr_cnt_ext              = '0;
    wr_cnt_ext[LOG2N-1:0]   = wr_cnt;
    wr_idx                  = LOG2N'(bitrev(wr_cnt_ext, LOG2N));
  end

  assign in_ready = !full[wr_bank];
  assign in_fire  = in_valid && in_ready;
  assign wr_end   = in_fire && (wr_cnt == '1);
  assign out_fire = out_valid && out_ready;

  // A newly filled bank is read in the same cycle the FSM leaves RD_IDLE,
  // so frames stream back-to-back without a bubble.
  assign rd_go    = (state == RD_RUN) || full[rd_bank];
  assign rd_issue = rd_go && (!out_valid || out_ready);
  assign rd_end   = rd_issue && (rd_cnt == '1);

  // The RAM read register doubles as the output data register; masking gives
  // the zero reset/flush value without resetting the RAM.
  assign out_data = out_valid ? rd_data : '0;

  fft_bitrev_reorder_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (LOG2N + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (in_fire),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data (in_data),
    .rd_en   (rd_issue),
    .rd_addr ({rd_bank, rd_cnt}),
    .rd_data (rd_data)
  );

  always_comb begin
    state_n = state;
    full_n  = full;
    case (state)
      RD_IDLE: if (full[rd_bank] && !rd_end) state_n = RD_RUN;
      RD_RUN:  if (rd_end) state_n = RD_IDLE;
      default: state_n = RD_IDLE;
    endcase
    if (wr_end) full_n[wr_bank] = 1'b1;
    if (rd_end) full_n[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= RD_IDLE;
    else if (flush) state <= RD_IDLE;
    else            state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      full        <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      err_len     <= 1'b0;
      frames_done <= '0;
    end else if (flush) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      full        <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      err_len     <= 1'b0;
    end else begin
      full    <= full_n;
      err_len <= in_fire && (in_last != (wr_cnt == '1));
      if (in_fire) begin
        wr_cnt <= wr_cnt + LOG2N'(1);
        if (wr_end) wr_bank <= !wr_bank;
      end
      if (rd_issue) begin
        rd_cnt    <= rd_cnt + LOG2N'(1);
        out_valid <= 1'b1;
        out_last  <= (rd_cnt == '1);
        if (rd_end) rd_bank <= !rd_bank;
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (out_fire && out_last) frames_done <= frames_done + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LOG2N  = 3;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              in_valid, in_ready, in_last;
  logic [DATA_W-1:0] in_data, out_data;
  logic              out_valid, out_ready, out_last, err_len;
  logic [CNT_W-1:0]  frames_done;

  fft_bitrev_reorder #(
    .DATA_W (DATA_W),
    .LOG2N  (LOG2N),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .err_len     (err_len),
    .frames_done (frames_done)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned exp_frames = 0;
  int unsigned acc_cyc[$];
  int unsigned got_cyc[$];
  int unsigned err_cyc[$];
  logic [31:0] got_data[$];
  logic        got_last[$];
  int unsigned br_order[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic logic [31:0] smp(input int unsigned tag, input int unsigned bin);
    return {tag[15:0], bin[15:0]};
  endfunction

  task automatic clear_q();
    acc_cyc.delete(); got_cyc.delete(); err_cyc.delete();
    got_data.delete(); got_last.delete();
  endtask

  // One clock: log handshakes seen at this negedge, then advance to the next one.
  task automatic tick();
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
      got_cyc.push_back(cyc);
    end
    if (err_len) err_cyc.push_back(cyc);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_sample(input logic [31:0] d, input logic last);
    bit fired;
    fired    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 200 && !fired; i++) begin
      fired = in_ready;
      tick();
    end
    if (!fired) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic send_frame(input int unsigned tag, input int extra_last);
    for (int j = 0; j < 8; j++)
      send_sample(smp(tag, br_order[j]), (j == 7) || (j == extra_last));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input int unsigned n);
    for (int i = 0; i < 300 && got_data.size() < n; i++) tick();
    if (got_data.size() < n) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d beats required %0d", got_data.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL rst_err_len: got %b want 0", err_len); end
    checks++; if (frames_done !== '0) begin errors++; $display("FAIL rst_frames_done: got %0d want 0", frames_done); end
    rst = 1'b0;
    @(negedge clk); cyc++;
  endtask

  task automatic test_basic();
    clear_q();
    out_ready = 1'b1;
    send_frame(1, -1);
    drain(8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== smp(1, i)) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, got_data[i], smp(1, i)); end
      checks++;
      if (got_last[i] !== (i == 7)) begin errors++; $display("FAIL basic_last[%0d]: got %b want %b", i, got_last[i], (i == 7)); end
    end
    checks++;
    if (got_cyc[0] !== acc_cyc[7] + 2) begin errors++; $display("FAIL basic_latency: first out cycle %0d want %0d", got_cyc[0], acc_cyc[7] + 2); end
    exp_frames++;
    checks++;
    if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL basic_frames_done: got %0d want %0d", frames_done, exp_frames); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_q();
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) send_sample(smp(2 + k / 8, br_order[k % 8]), (k % 8) == 7);
    in_valid = 1'b0; in_last = 1'b0;
    drain(24);
    ok = 1'b1;
    for (int k = 0; k < 24; k++) if (acc_cyc[k] !== acc_cyc[0] + k) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_in_gap: accepts not contiguous, last at %0d want %0d", acc_cyc[23], acc_cyc[0] + 23); end
    ok = 1'b1;
    for (int k = 0; k < 24; k++) if (got_cyc[k] !== got_cyc[0] + k) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_out_gap: outputs not contiguous, last at %0d want %0d", got_cyc[23], got_cyc[0] + 23); end
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (got_data[k] !== smp(2 + k / 8, k % 8)) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, got_data[k], smp(2 + k / 8, k % 8)); end
    end
    exp_frames += 3;
    checks++;
    if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL b2b_frames_done: got %0d want %0d", frames_done, exp_frames); end
  endtask

  task automatic test_backpressure();
    clear_q();
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_sample(smp(5 + k / 8, br_order[k % 8]), (k % 8) == 7);
    in_data = smp(7, br_order[0]); in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
      checks++; if (out_data !== smp(5, 0)) begin errors++; $display("FAIL bp_hold_data: got %h want %h", out_data, smp(5, 0)); end
      tick();
    end
    checks++; if (acc_cyc.size() !== 16) begin errors++; $display("FAIL bp_accepts: got %0d want 16", acc_cyc.size()); end
    out_ready = 1'b1;
    for (int k = 16; k < 24; k++) send_sample(smp(7, br_order[k % 8]), (k % 8) == 7);
    in_valid = 1'b0; in_last = 1'b0;
    drain(24);
    checks++;
    if (acc_cyc[16] !== got_cyc[0] + 7) begin errors++; $display("FAIL bp_third_accept: cycle %0d want %0d", acc_cyc[16], got_cyc[0] + 7); end
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (got_data[k] !== smp(5 + k / 8, k % 8)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", k, got_data[k], smp(5 + k / 8, k % 8)); end
    end
    exp_frames += 3;
    checks++;
    if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL bp_frames_done: got %0d want %0d", frames_done, exp_frames); end
  endtask

  task automatic test_err_len();
    clear_q();
    out_ready = 1'b1;
    send_frame(8, 4);
    drain(8);
    repeat (3) tick();
    checks++; if (err_cyc.size() !== 1) begin errors++; $display("FAIL errlen_count: got %0d pulses want 1", err_cyc.size()); end
    checks++; if (err_cyc[0] !== acc_cyc[4] + 1) begin errors++; $display("FAIL errlen_when: cycle %0d want %0d", err_cyc[0], acc_cyc[4] + 1); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== smp(8, i)) begin errors++; $display("FAIL errlen_data[%0d]: got %h want %h", i, got_data[i], smp(8, i)); end
    end
    exp_frames++;
    checks++;
    if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL errlen_frames_done: got %0d want %0d", frames_done, exp_frames); end
  endtask

  task automatic test_rst_mid();
    clear_q();
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) send_sample(smp(9, br_order[j]), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_out_data: got %h want 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rstmid_out_last: got %b want 0", out_last); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL rstmid_err_len: got %b want 0", err_len); end
    checks++; if (frames_done !== '0) begin errors++; $display("FAIL rstmid_frames_done: got %0d want 0", frames_done); end
    tick();
    rst = 1'b0;
    exp_frames = 0;
    tick();
    clear_q();
    send_frame(10, -1);
    drain(8);
    repeat (4) tick();
    checks++; if (got_data.size() !== 8) begin errors++; $display("FAIL rstmid_beats: got %0d want 8", got_data.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== smp(10, i)) begin errors++; $display("FAIL rstmid_data[%0d]: got %h want %h", i, got_data[i], smp(10, i)); end
    end
    exp_frames++;
    checks++;
    if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL rstmid_frames_done: got %0d want %0d", frames_done, exp_frames); end
  endtask

  task automatic test_flush();
    clear_q();
    out_ready = 1'b0;
    send_frame(11, -1);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    checks++; if (out_data !== smp(11, 3)) begin errors++; $display("FAIL flush_pre_data: got %h want %h", out_data, smp(11, 3)); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL flush_out_data: got %h want 0", out_data); end
    checks++; if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL flush_frames_done: got %0d want %0d", frames_done, exp_frames); end
    clear_q();
    out_ready = 1'b1;
    send_frame(12, -1);
    drain(8);
    repeat (4) tick();
    checks++; if (got_data.size() !== 8) begin errors++; $display("FAIL flush_beats: got %0d want 8", got_data.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== smp(12, i)) begin errors++; $display("FAIL flush_data[%0d]: got %h want %h", i, got_data[i], smp(12, i)); end
    end
    exp_frames++;
    checks++;
    if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL flush_frames_done2: got %0d want %0d", frames_done, exp_frames); end
  endtask

  task automatic test_random();
    int unsigned sidx, ridx, err_seen;
    bit          prev_stall, prev_last;
    logic [31:0] prev_data, want;
    sidx = 0; ridx = 0; err_seen = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    for (int c = 0; c < 60000 && ridx < 8000; c++) begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          errors++;
          $display("FAIL rand_stall_hold: valid=%b data=%h want valid=1 data=%h", out_valid, out_data, prev_data);
        end
      end
      if (sidx < 8000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = smp(100 + sidx / 8, br_order[sidx % 8]);
        in_last  = (sidx % 8) == 7;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) sidx++;
      if (out_valid && out_ready) begin
        want = smp(100 + ridx / 8, ridx % 8);
        checks++;
        if (out_data !== want || out_last !== ((ridx % 8) == 7)) begin
          errors++;
          $display("FAIL rand_data[%0d]: got %h last=%b want %h last=%b", ridx, out_data, out_last, want, (ridx % 8) == 7);
        end
        ridx++;
      end
      if (err_len) err_seen++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++; if (ridx !== 8000) begin errors++; $display("FAIL rand_timeout: got %0d beats want 8000", ridx); end
    checks++; if (err_seen !== 0) begin errors++; $display("FAIL rand_err_len: got %0d pulses want 0", err_seen); end
    exp_frames += 1000;
    checks++;
    if (frames_done !== CNT_W'(exp_frames)) begin errors++; $display("FAIL rand_frames_done: got %0d want %0d", frames_done, CNT_W'(exp_frames)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_err_len();
    test_rst_mid();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
